// File: rtl/vga_pkg.sv
// Shared VGA definitions: per-axis region codes, default 640x480 timing and
// the delayed control bundle carried alongside framebuffer read data.
package vga_pkg;

  typedef enum logic [1:0] {
    REGION_VISIBLE = 2'd0,
    REGION_FRONT   = 2'd1,
    REGION_SYNC    = 2'd2,
    REGION_BACK    = 2'd3
  } region_t;

  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;
  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic data_enable;
    logic vblank;
    logic frame_start;
  } video_ctl_t;

  // $clog2 sizing, kept at least one bit wide for degenerate totals of 1.
  function automatic int unsigned counter_width(input int unsigned total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// One timing axis: wrapping position counter plus visible/front/sync/back
// region decode from cumulative porch boundaries.
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int unsigned VISIBLE = VGA_H_VISIBLE,
  parameter int unsigned FRONT   = VGA_H_FRONT,
  parameter int unsigned SYNC    = VGA_H_SYNC,
  parameter int unsigned BACK    = VGA_H_BACK,
  localparam int unsigned W      = counter_width(VISIBLE + FRONT + SYNC + BACK)
) (
  input  logic         i_Clock,
  input  logic         i_Reset,
  input  logic         i_Clear,
  input  logic         i_Advance,
  output logic [W-1:0] o_Count,
  output logic         o_Wrap,
  output region_t      o_Region
);

  localparam int unsigned TOTAL     = VISIBLE + FRONT + SYNC + BACK;
  localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
  // One extra bit so a boundary equal to TOTAL still compares correctly.
  localparam logic [W:0] FRONT_START = (W+1)'(VISIBLE);
  localparam logic [W:0] SYNC_START  = (W+1)'(VISIBLE + FRONT);
  localparam logic [W:0] BACK_START  = (W+1)'(VISIBLE + FRONT + SYNC);

  logic [W:0] count_ext;

  assign count_ext = {1'b0, o_Count};
  assign o_Wrap    = i_Advance && (o_Count == LAST);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      o_Count <= '0;
    end else if (i_Clear) begin
      o_Count <= '0;
    end else if (i_Advance) begin
      o_Count <= (o_Count == LAST) ? '0 : o_Count + W'(1);
    end
  end

  always_comb begin
    o_Region = REGION_BACK;
    if (count_ext < FRONT_START)      o_Region = REGION_VISIBLE;
    else if (count_ext < SYNC_START)  o_Region = REGION_FRONT;
    else if (count_ext < BACK_START)  o_Region = REGION_SYNC;
  end

endmodule

// File: rtl/vga_scanout.sv
// VGA raster scanout: pixel-tick divider, H/V timing, scaled framebuffer
// addressing and latency-matched sync/enable outputs.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int unsigned BITS_PER_PIXEL  = 4,
  parameter int unsigned H_VISIBLE       = VGA_H_VISIBLE,
  parameter int unsigned H_FRONT         = VGA_H_FRONT,
  parameter int unsigned H_SYNC          = VGA_H_SYNC,
  parameter int unsigned H_BACK          = VGA_H_BACK,
  parameter int unsigned V_VISIBLE       = VGA_V_VISIBLE,
  parameter int unsigned V_FRONT         = VGA_V_FRONT,
  parameter int unsigned V_SYNC          = VGA_V_SYNC,
  parameter int unsigned V_BACK          = VGA_V_BACK,
  parameter int unsigned CLOCK_DIVIDE    = 4,
  parameter logic        HSYNC_POLARITY  = 1'b0,
  parameter logic        VSYNC_POLARITY  = 1'b0,
  parameter int unsigned FB_READ_LATENCY = 1,
  parameter int unsigned SCALE_SHIFT     = 0
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset,
  input  logic                      i_Enable,
  input  logic [31:0]               i_Fb_Base_Addr,
  input  logic [BITS_PER_PIXEL-1:0] i_Fb_Read_Data,
  output logic [31:0]               o_Fb_Read_Addr,
  output logic                      o_Fb_Read_Enable,
  output logic [BITS_PER_PIXEL-1:0] o_RGB,
  output logic                      o_Horizontal_Sync,
  output logic                      o_Vertical_Sync,
  output logic                      o_Data_Enable,
  output logic                      o_Frame_Start,
  output logic                      o_Vblank
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HW      = counter_width(H_TOTAL);
  localparam int unsigned VW      = counter_width(V_TOTAL);
  localparam int unsigned CW      = counter_width(CLOCK_DIVIDE);

  localparam logic [CW-1:0] TICK_LAST  = CW'(CLOCK_DIVIDE - 1);
  localparam logic [31:0]   ROW_STEP   = 32'(H_VISIBLE >> SCALE_SHIFT);
  localparam logic [VW-1:0] SCALE_MASK = VW'((1 << SCALE_SHIFT) - 1);

  logic          active;
  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic [HW-1:0] h_count;
  logic [VW-1:0] v_count;
  logic          h_wrap;
  logic          v_wrap;
  region_t       h_region;
  region_t       v_region;
  logic          visible;
  logic [31:0]   row_start;
  logic [31:0]   base_q;
  logic          primed;
  logic [31:0]   eff_base;
  logic [31:0]   fb_addr;
  video_ctl_t    ctl_now;
  video_ctl_t    ctl_late;

  assign active = i_Enable & ~i_Reset;
  assign tick   = i_Enable && (tick_cnt == TICK_LAST);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      tick_cnt <= '0;
    end else if (!i_Enable || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CW'(1);
    end
  end

  vga_timing_counter #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK)
  ) u_h_counter (
    .i_Clock   (i_Clock),
    .i_Reset   (i_Reset),
    .i_Clear   (~i_Enable),
    .i_Advance (tick),
    .o_Count   (h_count),
    .o_Wrap    (h_wrap),
    .o_Region  (h_region)
  );

  vga_timing_counter #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK)
  ) u_v_counter (
    .i_Clock   (i_Clock),
    .i_Reset   (i_Reset),
    .i_Clear   (~i_Enable),
    .i_Advance (h_wrap),
    .o_Count   (v_count),
    .o_Wrap    (v_wrap),
    .o_Region  (v_region)
  );

  // Row start steps one scaled row whenever the new line begins a new source row.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      row_start <= '0;
    end else if (!i_Enable || v_wrap) begin
      row_start <= '0;
    end else if (h_wrap && (((v_count + VW'(1)) & SCALE_MASK) == '0)) begin
      row_start <= row_start + ROW_STEP;
    end
  end

  // The first active cycle after reset/enable reads the live base and latches it,
  // so scanning starts at the new base without an extra idle cycle.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      primed <= 1'b0;
      base_q <= '0;
    end else if (!i_Enable) begin
      primed <= 1'b0;
    end else begin
      primed <= 1'b1;
      if (!primed || v_wrap) base_q <= i_Fb_Base_Addr;
    end
  end

  assign eff_base = primed ? base_q : i_Fb_Base_Addr;
  assign fb_addr  = eff_base + row_start + (32'(h_count) >> SCALE_SHIFT);
  assign visible  = (h_region == REGION_VISIBLE) && (v_region == REGION_VISIBLE);

  assign o_Fb_Read_Enable = active & visible;
  assign o_Fb_Read_Addr   = active ? fb_addr : '0;

  always_comb begin
    ctl_now             = '0;
    ctl_now.hsync       = active && (h_region == REGION_SYNC);
    ctl_now.vsync       = active && (v_region == REGION_SYNC);
    ctl_now.data_enable = active && visible;
    ctl_now.vblank      = active && (v_region != REGION_VISIBLE);
    ctl_now.frame_start = active && (h_count == '0) && (v_count == '0) && (tick_cnt == '0);
  end

  generate
    if (FB_READ_LATENCY == 0) begin : g_no_delay
      assign ctl_late = ctl_now;
    end else begin : g_delay
      video_ctl_t pipe [FB_READ_LATENCY];

      always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
          for (int unsigned i = 0; i < FB_READ_LATENCY; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= ctl_now;
          for (int unsigned i = 1; i < FB_READ_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign ctl_late = pipe[FB_READ_LATENCY-1];
    end
  endgenerate

  // Gating with active makes disable and reset take effect without waiting out the pipeline.
  assign o_Horizontal_Sync = (active && ctl_late.hsync) ? HSYNC_POLARITY : ~HSYNC_POLARITY;
  assign o_Vertical_Sync   = (active && ctl_late.vsync) ? VSYNC_POLARITY : ~VSYNC_POLARITY;
  assign o_Data_Enable     = active & ctl_late.data_enable;
  assign o_Vblank          = active & ctl_late.vblank;
  assign o_Frame_Start     = active & ctl_late.frame_start;
  assign o_RGB             = (active && ctl_late.data_enable) ? i_Fb_Read_Data : '0;

endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 SHALL expose parameter BITS_PER_PIXEL, default 4, width of pixel data and o_RGB.
REQ-002 SHALL expose parameters H_VISIBLE/H_FRONT/H_SYNC/H_BACK, defaults 640/16/96/48, horizontal timing in pixel ticks.
REQ-003 SHALL expose parameters V_VISIBLE/V_FRONT/V_SYNC/V_BACK, defaults 480/10/2/33, vertical timing in lines.
REQ-004 SHALL expose parameter CLOCK_DIVIDE, default 4, i_Clock cycles per pixel tick (>=1).
REQ-005 SHALL expose parameters HSYNC_POLARITY and VSYNC_POLARITY, default 0 each, active sync level (0 = active-low).
REQ-006 SHALL expose parameter FB_READ_LATENCY, default 1, framebuffer read latency in i_Clock cycles (0..8).
REQ-007 SHALL expose parameter SCALE_SHIFT, default 0, pixel replication factor 2^SCALE_SHIFT in both axes (0..3).
REQ-008 Ports, one clock; reset is asynchronous and active-high:
  i_Clock  in  1  system clock
  i_Reset  in  1  asynchronous active-high reset
  i_Enable  in  1  scan enable
  i_Fb_Base_Addr  in  32  framebuffer base address (pixel units)
  i_Fb_Read_Data  in  BITS_PER_PIXEL  read data, valid FB_READ_LATENCY cycles after request
  o_Fb_Read_Addr  out  32  pixel read address
  o_Fb_Read_Enable  out  1  read request, high during visible ticks
  o_RGB  out  BITS_PER_PIXEL  pixel output, 0 outside visible
  o_Horizontal_Sync  out  1  hsync at HSYNC_POLARITY
  o_Vertical_Sync  out  1  vsync at VSYNC_POLARITY
  o_Data_Enable  out  1  visible-region flag
  o_Frame_Start  out  1  one-cycle pulse at pixel (0,0)
  o_Vblank  out  1  high when V counter >= V_VISIBLE

Function
REQ-009 A tick counter SHALL count 0..CLOCK_DIVIDE-1 and wrap; a pixel tick SHALL occur on cycles where it equals CLOCK_DIVIDE-1.
REQ-010 On each tick H SHALL increment, wrapping from H_TOTAL-1 to 0; V SHALL increment only on the H wrap, wrapping from V_TOTAL-1 to 0.
REQ-011 H and V SHALL be sized by $clog2 of H_TOTAL and V_TOTAL; no multiplier SHALL be used.
REQ-012 Region per axis SHALL be VISIBLE (<VISIBLE), FRONT, SYNC, BACK, bounded by cumulative parameter sums.
REQ-013 The frame base SHALL be latched from i_Fb_Base_Addr only on the tick wrapping (H_TOTAL-1, V_TOTAL-1) to (0,0); a mid-frame change SHALL have no effect until then.
REQ-014 o_Fb_Read_Addr SHALL equal base + (V>>SCALE_SHIFT)*(H_VISIBLE>>SCALE_SHIFT) + (H>>SCALE_SHIFT), computed with an incrementally maintained row-start register.
REQ-015 The row-start register SHALL advance by H_VISIBLE>>SCALE_SHIFT only on line wraps where the low SCALE_SHIFT bits of the new V are zero.
REQ-016 o_Fb_Read_Enable SHALL be high exactly when H and V are both in VISIBLE.
REQ-017 Sync, data-enable, vblank and frame-start SHALL be delayed by FB_READ_LATENCY cycles so they align with i_Fb_Read_Data.
REQ-018 o_RGB SHALL equal i_Fb_Read_Data when delayed data-enable is high, else 0.
REQ-019 o_Frame_Start SHALL pulse for one i_Clock cycle (delayed per REQ-017), not for CLOCK_DIVIDE cycles.
REQ-020 With i_Enable low, tick counter, H, V and row-start SHALL be held at 0, syncs inactive, o_RGB/o_Data_Enable/o_Fb_Read_Enable 0; scanning SHALL resume at (0,0) on the cycle after i_Enable rises, with base latched on that cycle.
REQ-021 CLOCK_DIVIDE=1 SHALL tick every cycle.

Reset
REQ-022 i_Reset SHALL asynchronously clear tick counter, H, V, row-start, base and all delay-pipeline stages.
REQ-023 During reset o_Horizontal_Sync=~HSYNC_POLARITY, o_Vertical_Sync=~VSYNC_POLARITY, all other outputs 0.
REQ-024 After reset deasserts the first tick SHALL occur CLOCK_DIVIDE cycles later, if i_Enable is high.

Structure
REQ-025 Region encodings (VISIBLE, FRONT, SYNC, BACK) and default 640x480 timing constants SHALL live in shared package vga_pkg.
REQ-026 H/V counting and region decode SHALL be sub-module vga_timing_counter, instantiated once per axis.

Verification
REQ-027 Params H 8/2/3/3, V 4/1/2/1, DIVIDE 2, LATENCY 0: hsync low for 6 clocks per 32-clock line; vsync low for 2 lines per 8.
REQ-028 Same params, base 0x100: addresses 0x100..0x107 on line 0, 0x118..0x11F on line 3.
REQ-029 SCALE_SHIFT=1: lines 0 and 1 both read 0x100,0x100,0x101,0x101,0x102,0x102,0x103,0x103.
REQ-030 Base changed to 0x200 mid-frame: remaining lines keep 0x100; next frame line 0 starts 0x200.
REQ-031 LATENCY 3, HSYNC_POLARITY 1: RGB/DE/hsync shifted 3 cycles vs o_Fb_Read_Enable; hsync high-active.
REQ-032 Reset asserted mid-line, and i_Enable dropped mid-frame: outputs at REQ-023 values immediately; restart at address base+0.
